// File: rtl/ssp_uart_tx_core.sv
// ssp_uart_tx_core: parametrised UART transmit engine.
// Power-of-two TX FIFO feeding a start/data/parity/stop serialiser.
// Baud divider, parity mode and stop-bit count are latched per frame.
// Frame start is optionally gated by a synchronised, active-low CTS.
module ssp_uart_tx_core #(
  parameter int pDataWidth  = 8,
  parameter int pFIFO_Depth = 2,
  parameter int pBaudWidth  = 16
) (
  input  logic                  Rst,
  input  logic                  Clk,
  input  logic [pBaudWidth-1:0] Baud_Div,
  input  logic [1:0]            Parity_Mode,
  input  logic                  Stop2,
  input  logic                  CTS_En,
  input  logic                  xCTS,
  input  logic                  WE,
  input  logic [pDataWidth-1:0] DI,
  input  logic                  Ovr_Clr,
  output logic                  TxD,
  output logic                  TxIdle,
  output logic                  TF_Empty,
  output logic                  TF_Full,
  output logic [pFIFO_Depth:0]  TF_Cnt,
  output logic                  Ovr
);

  localparam int Entries = 1 << pFIFO_Depth;
  localparam int PW      = (pFIFO_Depth > 0) ? pFIFO_Depth : 1;
  localparam int IW      = $clog2(pDataWidth);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2
  } state_t;

  state_t                  state;
  logic [pDataWidth-1:0]   mem [Entries];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [1:0]              cts_sync;
  logic [pBaudWidth-1:0]   bit_cnt, div_l;
  logic [pDataWidth-1:0]   shreg;
  logic [IW-1:0]           bit_idx;
  logic [1:0]              pmode_l;
  logic                    stop2_l;
  logic                    par_bit;

  logic                    wr_acc, pop, cts_ok, bit_end, frame_end;
  logic [pDataWidth-1:0]   head;

  // With a single-entry FIFO the pointer never moves; otherwise it wraps naturally.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (Entries == 1) return '0;
    else              return p + 1'b1;
  endfunction

  assign TF_Empty = (TF_Cnt == '0);
  assign TF_Full  = (TF_Cnt == (pFIFO_Depth+1)'(Entries));
  assign TxIdle   = (state == ST_IDLE) && TF_Empty;
  assign head     = mem[rd_ptr];

  // Frame-start decision: pop happens from IDLE or at the end of the last stop bit.
  always_comb begin
    // NOTE: every signal gets a value on every path so no latch is inferred.
    wr_acc    = WE && !TF_Full;
    cts_ok    = !CTS_En || !cts_sync[1];
    bit_end   = (bit_cnt == '0);
    frame_end = bit_end && (((state == ST_STOP1) && !stop2_l) || (state == ST_STOP2));
    pop       = !TF_Empty && cts_ok && ((state == ST_IDLE) || frame_end);
  end

  // Two-flop synchroniser for the asynchronous CTS line (idles deasserted).
  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (Rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], xCTS};
  end

  // FIFO storage: written only on an accepted write.
  always_ff @(posedge Clk) begin
    // NOTE: the data array is deliberately not reset; occupancy is tracked by TF_Cnt.
    if (wr_acc) mem[wr_ptr] <= DI;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      TF_Cnt <= '0;
      Ovr    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, pop})
        2'b10:   TF_Cnt <= TF_Cnt + 1'b1;
        2'b01:   TF_Cnt <= TF_Cnt - 1'b1;
        default: TF_Cnt <= TF_Cnt;
      endcase
      if (WE && TF_Full) Ovr <= 1'b1;
      else if (Ovr_Clr)  Ovr <= 1'b0;
    end
  end

  // Transmit FSM with registered serial output.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= ST_IDLE;
      TxD     <= 1'b1;
      bit_cnt <= '0;
      div_l   <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      pmode_l <= 2'b00;
      stop2_l <= 1'b0;
      par_bit <= 1'b0;
    end else if (pop) begin
      state   <= ST_START;
      TxD     <= 1'b0;
      shreg   <= head;
      bit_cnt <= Baud_Div;
      div_l   <= Baud_Div;
      pmode_l <= Parity_Mode;
      stop2_l <= Stop2;
      case (Parity_Mode)
        2'b01:   par_bit <= ~^head;
        2'b10:   par_bit <= ^head;
        default: par_bit <= 1'b1;
      endcase
    end else if (state != ST_IDLE) begin
      if (!bit_end) begin
        bit_cnt <= bit_cnt - 1'b1;
      end else begin
        bit_cnt <= div_l;
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            TxD     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
          ST_DATA: begin
            if (bit_idx == IW'(pDataWidth-1)) begin
              if (pmode_l != 2'b00) begin
                state <= ST_PARITY;
                TxD   <= par_bit;
              end else begin
                state <= ST_STOP1;
                TxD   <= 1'b1;
              end
            end else begin
              TxD     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
          ST_PARITY: begin
            state <= ST_STOP1;
            TxD   <= 1'b1;
          end
          ST_STOP1: begin
            state <= stop2_l ? ST_STOP2 : ST_IDLE;
            TxD   <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            TxD   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssp_uart_tx_core.sv
// Directed testbench for ssp_uart_tx_core: default 8-bit instance plus a 9-bit instance.
module tb_ssp_uart_tx_core;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] Baud_Div = 16'd3;
  logic [1:0]  Parity_Mode = 2'b00;
  logic        Stop2 = 1'b0;
  logic        CTS_En = 1'b0;
  logic        xCTS = 1'b1;
  logic        WE = 1'b0;
  logic [7:0]  DI = 8'h00;
  logic        Ovr_Clr = 1'b0;
  logic        TxD, TxIdle, TF_Empty, TF_Full, Ovr;
  logic [2:0]  TF_Cnt;

  logic [15:0] Baud_Div9 = 16'd0;
  logic        WE9 = 1'b0;
  logic [8:0]  DI9 = 9'h000;
  logic        TxD9, TxIdle9, TF_Empty9, TF_Full9, Ovr9;
  logic [2:0]  TF_Cnt9;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  ssp_uart_tx_core u_dut (
    .Rst(Rst), .Clk(Clk), .Baud_Div(Baud_Div), .Parity_Mode(Parity_Mode),
    .Stop2(Stop2), .CTS_En(CTS_En), .xCTS(xCTS), .WE(WE), .DI(DI),
    .Ovr_Clr(Ovr_Clr), .TxD(TxD), .TxIdle(TxIdle), .TF_Empty(TF_Empty),
    .TF_Full(TF_Full), .TF_Cnt(TF_Cnt), .Ovr(Ovr)
  );

  ssp_uart_tx_core #(.pDataWidth(9)) u_dut9 (
    .Rst(Rst), .Clk(Clk), .Baud_Div(Baud_Div9), .Parity_Mode(2'b00),
    .Stop2(1'b0), .CTS_En(1'b0), .xCTS(1'b1), .WE(WE9), .DI(DI9),
    .Ovr_Clr(1'b0), .TxD(TxD9), .TxIdle(TxIdle9), .TF_Empty(TF_Empty9),
    .TF_Full(TF_Full9), .TF_Cnt(TF_Cnt9), .Ovr(Ovr9)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    WE = 1'b1;
    DI = d;
    tick();
    WE = 1'b0;
  endtask

  // Records the line level at the start of each bit and whether it held for the full bit.
  task automatic sample_frame(input bit w9, input int nbits, input int per,
                              output logic [63:0] bits, output bit stable);
    logic first;
    bits   = '0;
    stable = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      first   = w9 ? TxD9 : TxD;
      bits[b] = first;
      for (int c = 0; c < per; c++) begin
        if ((w9 ? TxD9 : TxD) !== first) stable = 1'b0;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick(); tick();
    tests++; if (TxD !== 1'b1)     begin fails++; $display("FAIL reset_txd got=%b want=1", TxD); end
    tests++; if (TxIdle !== 1'b1)  begin fails++; $display("FAIL reset_txidle got=%b want=1", TxIdle); end
    tests++; if (TF_Empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b want=1", TF_Empty); end
    tests++; if (TF_Full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b want=0", TF_Full); end
    tests++; if (TF_Cnt !== 3'd0)  begin fails++; $display("FAIL reset_cnt got=%0d want=0", TF_Cnt); end
    tests++; if (Ovr !== 1'b0)     begin fails++; $display("FAIL reset_ovr got=%b want=0", Ovr); end
    tests++; if (TxD9 !== 1'b1 || TF_Cnt9 !== 3'd0) begin fails++; $display("FAIL reset_dut9 got=%b/%0d want=1/0", TxD9, TF_Cnt9); end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_8n1();
    logic [63:0] bits;
    bit stable;
    Baud_Div = 16'd3; Parity_Mode = 2'b00; Stop2 = 1'b0;
    write_word(8'hA5);
    tests++; if (TF_Cnt !== 3'd1) begin fails++; $display("FAIL 8n1_cnt_after_write got=%0d want=1", TF_Cnt); end
    tests++; if (TxD !== 1'b1)    begin fails++; $display("FAIL 8n1_txd_after_write got=%b want=1", TxD); end
    tick();
    tests++; if (TF_Cnt !== 3'd0) begin fails++; $display("FAIL 8n1_cnt_after_pop got=%0d want=0", TF_Cnt); end
    tests++; if (TxD !== 1'b0 || TxIdle !== 1'b0) begin fails++; $display("FAIL 8n1_start got txd=%b idle=%b want 0/0", TxD, TxIdle); end
    sample_frame(1'b0, 10, 4, bits, stable);
    tests++; if (bits[9:0] !== 10'h34A || !stable) begin fails++; $display("FAIL 8n1_bits got=%h stable=%b want=34a/1", bits[9:0], stable); end
    tests++; if (TxIdle !== 1'b1) begin fails++; $display("FAIL 8n1_idle_40 got=%b want=1", TxIdle); end
  endtask

  task automatic test_parity();
    logic [1:0]  mode [3] = '{2'b10, 2'b01, 2'b11};
    logic        st2  [3] = '{1'b1, 1'b0, 1'b0};
    logic [15:0] div  [3] = '{16'd3, 16'd0, 16'd0};
    int          nb   [3] = '{12, 11, 11};
    logic [11:0] exp  [3] = '{12'hE0E, 12'h40E, 12'h60E};
    logic [63:0] bits;
    bit stable;
    for (int i = 0; i < 3; i++) begin
      Parity_Mode = mode[i]; Stop2 = st2[i]; Baud_Div = div[i];
      write_word(8'h07);
      tick();
      sample_frame(1'b0, nb[i], int'(div[i]) + 1, bits, stable);
      tests++; if (bits[11:0] !== exp[i] || !stable) begin fails++; $display("FAIL parity_mode%0d got=%h stable=%b want=%h", mode[i], bits[11:0], stable, exp[i]); end
      tests++; if (TxIdle !== 1'b1) begin fails++; $display("FAIL parity_len_mode%0d idle got=%b want=1", mode[i], TxIdle); end
    end
    Parity_Mode = 2'b00; Stop2 = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0]  words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [63:0] bits;
    bit stable;
    int waited;
    Baud_Div = 16'd1; CTS_En = 1'b1; xCTS = 1'b1;
    tick(); tick(); tick();
    WE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      DI = words[i];
      tick();
    end
    WE = 1'b0;
    tests++; if (TF_Cnt !== 3'd4 || TF_Full !== 1'b1) begin fails++; $display("FAIL ovf_full got cnt=%0d full=%b want 4/1", TF_Cnt, TF_Full); end
    tests++; if (Ovr !== 1'b1)  begin fails++; $display("FAIL ovf_flag got=%b want=1", Ovr); end
    tests++; if (TxD !== 1'b1 || TxIdle !== 1'b0) begin fails++; $display("FAIL ovf_blocked got txd=%b idle=%b want 1/0", TxD, TxIdle); end
    xCTS = 1'b0;
    waited = 0;
    while (TxD !== 1'b0 && waited < 10) begin
      tick();
      waited++;
    end
    tests++; if (waited != 3) begin fails++; $display("FAIL ovf_cts_latency got=%0d want=3 cycles", waited); end
    sample_frame(1'b0, 40, 2, bits, stable);
    tests++; if (bits[39:0] !== {1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0} || !stable) begin
      fails++; $display("FAIL ovf_back_to_back got=%h stable=%b want=%h", bits[39:0], stable, {1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0});
    end
    tests++; if (TxIdle !== 1'b1 || TF_Cnt !== 3'd0) begin fails++; $display("FAIL ovf_drained got idle=%b cnt=%0d want 1/0", TxIdle, TF_Cnt); end
    tests++; if (Ovr !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b want=1", Ovr); end
    Ovr_Clr = 1'b1;
    tick();
    Ovr_Clr = 1'b0;
    tests++; if (Ovr !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b want=0", Ovr); end
    CTS_En = 1'b0; xCTS = 1'b1;
  endtask

  task automatic test_simultaneous();
    logic [63:0] bits;
    bit stable;
    Baud_Div = 16'd1; CTS_En = 1'b1; xCTS = 1'b1;
    tick(); tick(); tick();
    write_word(8'h3C);
    tests++; if (TF_Cnt !== 3'd1) begin fails++; $display("FAIL simul_hold got=%0d want=1", TF_Cnt); end
    xCTS = 1'b0;
    tick(); tick();
    WE = 1'b1; DI = 8'hC3;
    tick();
    WE = 1'b0;
    tests++; if (TF_Cnt !== 3'd1 || TxD !== 1'b0) begin fails++; $display("FAIL simul_cnt got cnt=%0d txd=%b want 1/0", TF_Cnt, TxD); end
    sample_frame(1'b0, 20, 2, bits, stable);
    tests++; if (bits[19:0] !== {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0} || !stable) begin
      fails++; $display("FAIL simul_order got=%h stable=%b want=%h", bits[19:0], stable, {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0});
    end
    tests++; if (TxIdle !== 1'b1) begin fails++; $display("FAIL simul_idle got=%b want=1", TxIdle); end
    CTS_En = 1'b0; xCTS = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] bits;
    bit stable;
    Baud_Div = 16'd3;
    write_word(8'h00);
    write_word(8'h00);
    repeat (8) tick();
    tests++; if (TxD !== 1'b0 || TF_Cnt !== 3'd1) begin fails++; $display("FAIL rstmid_pre got txd=%b cnt=%0d want 0/1", TxD, TF_Cnt); end
    #2 Rst = 1'b1;
    #1;
    tests++; if (TxD !== 1'b1)    begin fails++; $display("FAIL rstmid_txd got=%b want=1", TxD); end
    tests++; if (TF_Cnt !== 3'd0 || TxIdle !== 1'b1) begin fails++; $display("FAIL rstmid_state got cnt=%0d idle=%b want 0/1", TF_Cnt, TxIdle); end
    tick();
    Rst = 1'b0;
    Baud_Div = 16'd0;
    tick();
    write_word(8'hA5);
    tick();
    sample_frame(1'b0, 10, 1, bits, stable);
    tests++; if (bits[9:0] !== 10'h34A || !stable) begin fails++; $display("FAIL rstmid_clean got=%h want=34a", bits[9:0]); end
    tests++; if (TxIdle !== 1'b1) begin fails++; $display("FAIL rstmid_idle got=%b want=1", TxIdle); end
  endtask

  task automatic test_width9();
    logic [63:0] bits;
    bit stable;
    Baud_Div9 = 16'd0;
    WE9 = 1'b1; DI9 = 9'h1FF;
    tick();
    WE9 = 1'b0;
    tick();
    Baud_Div9 = 16'd5;
    tests++; if (TxD9 !== 1'b0) begin fails++; $display("FAIL w9_start got=%b want=0", TxD9); end
    sample_frame(1'b1, 11, 1, bits, stable);
    tests++; if (bits[10:0] !== 11'h7FE || !stable) begin fails++; $display("FAIL w9_bits got=%h stable=%b want=7fe", bits[10:0], stable); end
    tests++; if (TxIdle9 !== 1'b1 || TF_Empty9 !== 1'b1 || TF_Full9 !== 1'b0 || Ovr9 !== 1'b0) begin
      fails++; $display("FAIL w9_idle got idle=%b empty=%b full=%b ovr=%b want 1/1/0/0", TxIdle9, TF_Empty9, TF_Full9, Ovr9);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_overflow();
    test_simultaneous();
    test_reset_mid_frame();
    test_width9();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ssp_uart_tx_core.md
# ssp_uart_tx_core

Parametrised UART transmit engine for the next-generation SSP UART. It generalises the fixed-format transmitter with a configurable character width, a power-of-two transmit FIFO, programmable parity and stop bits, a per-frame latched baud divider and CTS flow control. It sits between the SSP register file, which drives writes and configuration, and the RS-232/RS-485 line drivers, which take `TxD` and `TxIdle`.

## Interface
- `pDataWidth`, default 8: character width in bits; legal range 5..9.
- `pFIFO_Depth`, default 2: log2 of the FIFO entry count (2 gives 4 entries); legal range 0..5.
- `pBaudWidth`, default 16: width of the baud divider.
- `Rst`  in  1: asynchronous reset, active-high.
- `Clk`  in  1: system clock; all logic is on the rising edge.
- `Baud_Div`  in  pBaudWidth: bit period in Clk cycles is `Baud_Div+1`.
- `Parity_Mode`  in  2: 00 none, 01 odd, 10 even, 11 forced mark (1).
- `Stop2`  in  1: 1 selects two stop bits, 0 selects one.
- `CTS_En`  in  1: 1 gates frame start on `xCTS`.
- `xCTS`  in  1: clear-to-send, active-low; synchronised internally with 2 flops.
- `WE`  in  1: write strobe, one word per cycle.
- `DI`  in  pDataWidth: write data.
- `Ovr_Clr`  in  1: clears `Ovr`.
- `TxD`  out  1: serial output, registered.
- `TxIdle`  out  1: FSM is in IDLE and the FIFO is empty.
- `TF_Empty`, `TF_Full`  out  1 each: FIFO status.
- `TF_Cnt`  out  pFIFO_Depth+1: FIFO occupancy.
- `Ovr`  out  1: sticky flag, set when a write arrives while the FIFO is full.

## Operation
- **FIFO**
  - Circular buffer with wrap-around read and write pointers.
  - A write is accepted only when `TF_Full=0` at that edge. If the FIFO is full, the write is dropped and `Ovr` is set, even when a pop occurs in the same cycle.
  - `TF_Cnt <= TF_Cnt + wr_acc - pop`. A simultaneous accepted write and pop leave the count unchanged.
  - If `Ovr_Clr` and an overflow occur in the same cycle, the set wins.
- **FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2.
- **Frame start (IDLE → START):** requires `TF_Empty=0` and (`CTS_En=0` or synchronised `xCTS=0`). On that edge the FSM:
  - pops the FIFO head into the shift register;
  - latches `Baud_Div`, `Parity_Mode` and `Stop2`;
  - loads the bit counter with `Baud_Div`.
- **Bit timing:** the bit counter decrements every cycle. The bit ends on the edge where the counter is 0; it then reloads and the FSM advances.
- **DATA:** sends `pDataWidth` bits, LSB first.
- **PARITY:** entered only when the latched mode is non-zero.
  - Odd: total ones in data plus parity is odd.
  - Even: total ones is even.
  - 11: parity bit is 1.
- **Stop bits:** STOP1 always. STOP2 only when the latched `Stop2=1`.
- **End of last stop bit:**
  - If the start condition holds, the FSM goes directly to START with no idle gap (back-to-back frames).
  - Otherwise it returns to IDLE.
- **CTS:** sampled only at frame start. Deasserting `xCTS` mid-frame does not abort the frame.
- **Configuration changes:** changes to the latched inputs mid-frame take effect at the next frame.

## Timing
- Reset values: `TxD=1`, `TxIdle=1`, `TF_Empty=1`, `TF_Full=0`, `TF_Cnt=0`, `Ovr=0`; FSM in IDLE; FIFO pointers 0.
- Reset is asynchronous. Asserting it mid-frame forces `TxD=1` immediately and discards the FIFO contents.
- Write latency, with the FIFO empty and the FSM idle:
  - `WE` sampled at edge N gives `TF_Cnt=1` after N.
  - The pop happens at edge N+1, after which `TF_Cnt=0`.
  - `TxD=0` is driven from edge N+1.
- Each bit lasts exactly `Baud_Div+1` cycles. `Baud_Div=0` gives a 1-cycle bit.
- Frame length is `(1 + pDataWidth + P + S) × (Baud_Div+1)` cycles, where P is 0 or 1 and S is 1 or 2.
- `TxIdle` rises on the edge the FSM returns to IDLE with the FIFO empty.
- The CTS synchroniser adds 2 cycles of latency from an `xCTS` edge to frame start.

## Test plan
- **8N1 single frame:** `Baud_Div=3`, write `0xA5` → `TxD` = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. Start bit begins at N+1. `TxIdle` returns to 1 after 40 cycles.
- **Parity:** write `0x07` with `Parity_Mode=10` → parity bit 1. With 01 → parity bit 0. With 11 → parity bit 1. 8E2 frame is 48 cycles at `Baud_Div=3`.
- **FIFO full and overflow:** `pFIFO_Depth=2`, `CTS_En=1`, `xCTS=1`, write 6 words → `TF_Full=1`, `TF_Cnt=4`, `Ovr=1`. Then set `xCTS=0` → the first 4 words are sent in order, back-to-back with no gap. `Ovr_Clr` then clears `Ovr`.
- **Simultaneous write and pop:** FIFO holds 1 word, FSM idle; `WE` on the pop edge → `TF_Cnt` stays 1 and the written word is sent next.
- **Reset mid-frame:** assert `Rst` during DATA → `TxD=1` within the same cycle, `TF_Cnt=0`, `TxIdle=1`. After release, a new write produces a clean frame.
- **Width and config change:** `pDataWidth=9`, `Baud_Div=0`, write `0x1FF` → 11-cycle frame. Changing `Baud_Div` mid-frame does not alter the current frame.
